// File: rtl/packet_pkg.sv
// Shared types for the multicast crossbar arbiter: port-index width, index type, output state.
package packet_pkg;

    localparam int unsigned NUM_PORTS_DEF = 4;
    localparam int unsigned PORT_IDX_W    = $clog2(NUM_PORTS_DEF);

    typedef logic [PORT_IDX_W-1:0] port_idx_t;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } out_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker for one output: first set request at or after the pointer, wrapping.
module rr_pick #(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt
);

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] idx;
        o_gnt = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < int'(N); k++) begin
            idx = IDX_W'((int'(i_ptr) + k) % int'(N));
            if (!found && i_req[idx]) begin
                o_gnt[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mc_arbiter.sv
// Multicast all-or-nothing output arbiter with per-output round-robin pointers.
// Optional starvation guard enabled by defining MC_ARB_STARVE_GUARD_EN.
module mc_arbiter
    import packet_pkg::*;
#(
    parameter  int unsigned NUM_PORTS    = 4,
    parameter  int unsigned STARVE_LIMIT = 16,
    localparam int unsigned IDX_W        = $clog2(NUM_PORTS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_PORTS-1:0]           req,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] dst,
    input  logic [NUM_PORTS-1:0]           eop,
    output logic [NUM_PORTS-1:0]           grant,
    output logic [NUM_PORTS*IDX_W-1:0]     mux_sel,
    output logic [NUM_PORTS-1:0]           active
);

    if (NUM_PORTS < 2 || NUM_PORTS > 16 || STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_cfg
        $error("mc_arbiter: parameter out of legal range");
    end

    out_state_e           r_state [NUM_PORTS];
    logic [IDX_W-1:0]     r_ptr   [NUM_PORTS];
    logic [IDX_W-1:0]     r_sel   [NUM_PORTS];
    logic [NUM_PORTS-1:0] r_mask  [NUM_PORTS];
    logic [NUM_PORTS-1:0] r_grant;

    logic [NUM_PORTS-1:0] w_dst     [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_out_req [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_win     [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_cand;
    logic [NUM_PORTS-1:0] w_new_grant;
    logic [NUM_PORTS-1:0] w_release;
    logic [NUM_PORTS-1:0] w_urg_onehot;
    logic [NUM_PORTS-1:0] w_urg_mask;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_dst
        assign w_dst[i] = dst[i*NUM_PORTS +: NUM_PORTS];
    end

    // Candidates see the registered state, so outputs released this cycle still look BUSY.
    always_comb begin
        w_cand = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            w_cand[i] = req[i] && (w_dst[i] != '0) && !r_grant[i];
            for (int o = 0; o < int'(NUM_PORTS); o++) begin
                if (w_dst[i][o] && (r_state[o] != FREE)) begin
                    w_cand[i] = 1'b0;
                end
            end
        end
    end

`ifdef MC_ARB_STARVE_GUARD_EN
    logic [7:0] r_wait [NUM_PORTS];

    always_comb begin
        logic found;
        found        = 1'b0;
        w_urg_onehot = '0;
        w_urg_mask   = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (!found && (r_wait[i] >= 8'(STARVE_LIMIT)) && req[i] && !r_grant[i]) begin
                w_urg_onehot[i] = 1'b1;
                w_urg_mask      = w_dst[i];
                found           = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_PORTS); i++) begin
                r_wait[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_PORTS); i++) begin
                if (w_new_grant[i]) begin
                    r_wait[i] <= '0;
                end else if (req[i] && !r_grant[i] && (r_wait[i] != 8'hFF)) begin
                    r_wait[i] <= r_wait[i] + 8'd1;
                end
            end
        end
    end
`else
    assign w_urg_onehot = '0;
    assign w_urg_mask   = '0;
`endif

    // Outputs claimed by the urgent port accept only that port.
    always_comb begin
        for (int o = 0; o < int'(NUM_PORTS); o++) begin
            w_out_req[o] = '0;
            for (int i = 0; i < int'(NUM_PORTS); i++) begin
                w_out_req[o][i] = w_cand[i] && w_dst[i][o] && (!w_urg_mask[o] || w_urg_onehot[i]);
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_pick
        rr_pick #(
            .N (NUM_PORTS)
        ) u_rr_pick (
            .i_req (w_out_req[o]),
            .i_ptr (r_ptr[o]),
            .o_gnt (w_win[o])
        );
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            w_new_grant[i] = w_cand[i];
            for (int o = 0; o < int'(NUM_PORTS); o++) begin
                if (w_dst[i][o] && !w_win[o][i]) begin
                    w_new_grant[i] = 1'b0;
                end
            end
            w_release[i] = r_grant[i] && eop[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant <= '0;
            for (int k = 0; k < int'(NUM_PORTS); k++) begin
                r_state[k] <= FREE;
                r_ptr[k]   <= '0;
                r_sel[k]   <= '0;
                r_mask[k]  <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_PORTS); i++) begin
                if (w_release[i]) begin
                    r_grant[i] <= 1'b0;
                    for (int o = 0; o < int'(NUM_PORTS); o++) begin
                        if (r_mask[i][o]) begin
                            r_state[o] <= FREE;
                        end
                    end
                end else if (w_new_grant[i]) begin
                    r_grant[i] <= 1'b1;
                    r_mask[i]  <= w_dst[i];
                end
            end
            for (int o = 0; o < int'(NUM_PORTS); o++) begin
                for (int i = 0; i < int'(NUM_PORTS); i++) begin
                    if (w_new_grant[i] && w_dst[i][o]) begin
                        r_state[o] <= BUSY;
                        r_sel[o]   <= IDX_W'(i);
                        r_ptr[o]   <= IDX_W'((i + 1) % int'(NUM_PORTS));
                    end
                end
            end
        end
    end

    assign grant = r_grant;

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        assign mux_sel[o*IDX_W +: IDX_W] = r_sel[o];
        assign active[o]                 = (r_state[o] == BUSY);
    end

endmodule

// File: tb/tb_mc_arbiter.sv
// Bench for mc_arbiter: directed vector table, starvation bound, random run against a model.
module tb_mc_arbiter;

    localparam int N     = 4;
    localparam int LIMIT = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*N-1:0] dst;
    logic [N-1:0]   eop;
    logic [N-1:0]   grant;
    logic [2*N-1:0] mux_sel;
    logic [N-1:0]   active;

    always #5 clk = ~clk;

    mc_arbiter #(
        .NUM_PORTS    (N),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .dst     (dst),
        .eop     (eop),
        .grant   (grant),
        .mux_sel (mux_sel),
        .active  (active)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: who owns each output, which ports hold grants, pointers.
    int           m_owner [N];
    int           m_sel   [N];
    int           m_ptr   [N];
    bit           m_gr    [N];
    logic [N-1:0] m_mask  [N];
`ifdef MC_ARB_STARVE_GUARD_EN
    int           m_wait  [N];
`endif

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_owner[k] = -1;
            m_sel[k]   = 0;
            m_ptr[k]   = 0;
            m_gr[k]    = 1'b0;
            m_mask[k]  = '0;
`ifdef MC_ARB_STARVE_GUARD_EN
            m_wait[k]  = 0;
`endif
        end
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N*N-1:0] d,
                              input logic [N-1:0] e);
        logic [N-1:0] dm [N];
        bit           cand [N];
        bit           newg [N];
        int           win [N];
        int           urg;
        int           p;
        logic [N-1:0] wmask;
        for (int i = 0; i < N; i++) dm[i] = d[i*N +: N];
        for (int i = 0; i < N; i++) begin
            cand[i] = r[i] && (dm[i] != '0) && !m_gr[i];
            for (int o = 0; o < N; o++) if (dm[i][o] && m_owner[o] != -1) cand[i] = 1'b0;
        end
        urg   = -1;
        wmask = '0;
`ifdef MC_ARB_STARVE_GUARD_EN
        for (int i = 0; i < N; i++) begin
            if (urg < 0 && m_wait[i] >= LIMIT && r[i] && !m_gr[i]) begin
                urg   = i;
                wmask = dm[i];
            end
        end
`endif
        for (int o = 0; o < N; o++) begin
            win[o] = -1;
            if (m_owner[o] == -1) begin
                for (int k = 0; k < N; k++) begin
                    p = (m_ptr[o] + k) % N;
                    if (win[o] < 0 && cand[p] && dm[p][o] && (!wmask[o] || p == urg)) win[o] = p;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            newg[i] = cand[i];
            for (int o = 0; o < N; o++) if (dm[i][o] && win[o] != i) newg[i] = 1'b0;
        end
`ifdef MC_ARB_STARVE_GUARD_EN
        for (int i = 0; i < N; i++) begin
            if (newg[i]) m_wait[i] = 0;
            else if (r[i] && !m_gr[i] && m_wait[i] < 255) m_wait[i]++;
        end
`endif
        for (int i = 0; i < N; i++) begin
            if (e[i] && m_gr[i]) begin
                m_gr[i] = 1'b0;
                for (int o = 0; o < N; o++) if (m_mask[i][o]) m_owner[o] = -1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (newg[i]) begin
                m_gr[i]   = 1'b1;
                m_mask[i] = dm[i];
                for (int o = 0; o < N; o++) begin
                    if (dm[i][o]) begin
                        m_owner[o] = i;
                        m_sel[o]   = i;
                        m_ptr[o]   = (i + 1) % N;
                    end
                end
            end
        end
    endtask

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = m_gr[i];
        return v;
    endfunction

    function automatic logic [N-1:0] exp_active();
        logic [N-1:0] v = '0;
        for (int o = 0; o < N; o++) v[o] = (m_owner[o] != -1);
        return v;
    endfunction

    function automatic logic [2*N-1:0] exp_mux();
        logic [2*N-1:0] v = '0;
        for (int o = 0; o < N; o++) v[o*2 +: 2] = 2'(m_sel[o]);
        return v;
    endfunction

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        req   = '0;
        dst   = '0;
        eop   = '0;
        #2;
        check({tag, "_rst_grant"}, 32'(grant), 32'h0);
        check({tag, "_rst_active"}, 32'(active), 32'h0);
        check({tag, "_rst_mux"}, 32'(mux_sel), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit           rst;
        logic [N-1:0] req;
        logic [N*N-1:0] dst;
        logic [N-1:0] eop;
        logic [N-1:0] g;
        logic [N-1:0] a;
        logic [2*N-1:0] m;
    } vec_t;

    function automatic vec_t v(bit rs, logic [N-1:0] r, logic [N*N-1:0] d, logic [N-1:0] e,
                               logic [N-1:0] g, logic [N-1:0] a, logic [2*N-1:0] m);
        vec_t x;
        x.rst = rs; x.req = r; x.dst = d; x.eop = e; x.g = g; x.a = a; x.m = m;
        return x;
    endfunction

    vec_t           tbl [$];
    logic [N-1:0]   r_r;
    logic [N-1:0]   r_e;
    logic [N*N-1:0] r_d;
    logic [N*N-1:0] all0;
    int             cyc;
    bit             got;

    initial begin
        rst_n = 1'b0;
        req   = '0;
        dst   = '0;
        eop   = '0;
        model_reset();
        all0  = {4'b0001, 4'b0001, 4'b0001, 4'b0001};

        // dst packed as {p3, p2, p1, p0}; mux_sel as {o3, o2, o1, o0}
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 4'b0001, {4'h0, 4'h0, 4'h0, 4'b0010}, 0, 4'b0001, 4'b0010, 8'h00));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0001, 0, 0, 8'h00));
        tbl.push_back(v(0, 4'b0110, {4'h0, 4'b0110, 4'b0010, 4'h0}, 0, 4'b0010, 4'b0010, 8'h04));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0010, 0, 0, 8'h04));
        tbl.push_back(v(0, 4'b1100, {4'b0100, 4'b0100, 4'h0, 4'h0}, 0, 4'b0100, 4'b0100, 8'h24));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 4'b1111, all0, 0,       4'b0001, 4'b0001, 8'h00));
        tbl.push_back(v(0, 4'b1111, all0, 4'b0001, 4'b0000, 4'b0000, 8'h00));
        tbl.push_back(v(0, 4'b1111, all0, 0,       4'b0010, 4'b0001, 8'h01));
        tbl.push_back(v(0, 4'b1111, all0, 4'b0010, 4'b0000, 4'b0000, 8'h01));
        tbl.push_back(v(0, 4'b1111, all0, 0,       4'b0100, 4'b0001, 8'h02));
        tbl.push_back(v(0, 4'b1111, all0, 4'b0100, 4'b0000, 4'b0000, 8'h02));
        tbl.push_back(v(0, 4'b1111, all0, 0,       4'b1000, 4'b0001, 8'h03));
        tbl.push_back(v(0, 4'b1111, all0, 4'b1000, 4'b0000, 4'b0000, 8'h03));
        tbl.push_back(v(0, 4'b1111, all0, 0,       4'b0001, 4'b0001, 8'h00));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 4'b0011, {4'h0, 4'h0, 4'b0010, 4'b0011}, 0, 4'b0001, 4'b0011, 8'h00));
        tbl.push_back(v(0, 4'b0010, {4'h0, 4'h0, 4'b0010, 4'b0011}, 4'b0001, 0, 0, 8'h00));
        tbl.push_back(v(0, 4'b0010, {4'h0, 4'h0, 4'b0010, 4'h0}, 0, 4'b0010, 4'b0010, 8'h04));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0010, 0, 0, 8'h04));
        tbl.push_back(v(0, 4'b0001, {4'h0, 4'h0, 4'h0, 4'b0001}, 0, 4'b0001, 4'b0001, 8'h04));
        tbl.push_back(v(0, 4'b0001, {4'h0, 4'h0, 4'h0, 4'b1111}, 4'b0100, 4'b0001, 4'b0001, 8'h04));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0001, 0, 0, 8'h04));

        @(posedge clk);
        #1;
        foreach (tbl[k]) begin
            if (tbl[k].rst) begin
                do_reset($sformatf("tbl%0d", k));
            end else begin
                req = tbl[k].req;
                dst = tbl[k].dst;
                eop = tbl[k].eop;
                @(posedge clk);
                #1;
                check($sformatf("tbl%0d_grant", k), 32'(grant), 32'(tbl[k].g));
                check($sformatf("tbl%0d_active", k), 32'(active), 32'(tbl[k].a));
                check($sformatf("tbl%0d_mux", k), 32'(mux_sel), 32'(tbl[k].m));
            end
        end

`ifdef MC_ARB_STARVE_GUARD_EN
        do_reset("starve");
        req = 4'b0111;
        dst = {4'h0, 4'b0011, 4'b0011, 4'b0011};
        eop = '0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (grant[1]) got = 1'b1;
            else eop = grant & 4'b0101;
        end
        check("starve_p1_bound", 32'(got && cyc <= LIMIT + 2), 32'h1);
`endif

        do_reset("rand");
        for (int c = 0; c < 400; c++) begin
            if (c == 200) do_reset("rand_mid");
            for (int i = 0; i < N; i++) begin
                r_r[i] = ($urandom_range(0, 3) != 0);
                r_e[i] = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 1) == 1) r_d[i*N +: N] = 4'b0001 << $urandom_range(0, 3);
                else r_d[i*N +: N] = 4'($urandom_range(1, 15));
            end
            req = r_r;
            dst = r_d;
            eop = r_e;
            model_step(r_r, r_d, r_e);
            @(posedge clk);
            #1;
            check($sformatf("rand%0d_grant", c), 32'(grant), 32'(exp_grant()));
            check($sformatf("rand%0d_active", c), 32'(active), 32'(exp_active()));
            check($sformatf("rand%0d_mux", c), 32'(mux_sel), 32'(exp_mux()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_arbiter.md
MC_ARBITER -- requirements
Module: mc_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4, SHALL set the count of input ports and output ports (legal range 2..16).
REQ-002 Parameter STARVE_LIMIT, default 16, SHALL set the wait-cycle threshold for the starvation guard (legal range 1..255).
REQ-003 Port list SHALL be:
  clk       in   1            single clock; all state on rising edge
  rst_n     in   1            asynchronous, active-low reset
  req       in   NUM_PORTS    port i has a packet head ready
  dst       in   NUM_PORTS*NUM_PORTS  port i multi-hot output mask at [i*NUM_PORTS +: NUM_PORTS]
  eop       in   NUM_PORTS    port i transfers its last flit this cycle
  grant     out  NUM_PORTS    registered; port i owns all its requested outputs
  mux_sel   out  NUM_PORTS*PORT_IDX_W  output o source index at [o*PORT_IDX_W +: PORT_IDX_W]
  active    out  NUM_PORTS    registered; output o is driven by an owner

Function
REQ-004 Each output SHALL hold state FREE or BUSY plus a PORT_IDX_W-bit owner index and a round-robin pointer.
REQ-005 Port i SHALL be a candidate when req[i]=1, dst mask non-zero, grant[i]=0, and every output in its mask is FREE.
REQ-006 Each FREE output SHALL select among candidates requesting it, priority starting at its pointer and wrapping modulo NUM_PORTS.
REQ-007 A candidate SHALL be granted only if it wins every output in its mask (all-or-nothing); partial winners SHALL lock nothing.
REQ-008 On grant decided in cycle t: grant[i], active[o], mux_sel[o]=i, BUSY state SHALL appear from cycle t+1; minimum req-to-grant latency one cycle.
REQ-009 The dst mask SHALL be captured at grant; dst and req changes while grant[i]=1 SHALL be ignored.
REQ-010 eop[i] sampled with grant[i]=1 SHALL clear grant[i] and free its outputs at the next edge; freed outputs SHALL be arbitrated no earlier than the cycle after release.
REQ-011 eop[i] with grant[i]=0 SHALL be ignored.
REQ-012 An output's pointer SHALL advance to (winner+1) mod NUM_PORTS only when the winner is granted; otherwise unchanged.
REQ-013 While FREE, active[o]=0 and mux_sel[o] SHALL hold its last value.
REQ-014 Same-cycle eop on one port and new candidates SHALL not interact: candidates see outputs still BUSY that cycle.

Reset
REQ-015 rst_n low SHALL asynchronously clear grant, active, mux_sel, all pointers, owners, wait counters; all outputs FREE.
REQ-016 Reset mid-packet SHALL abandon ownership; no grant SHALL persist after release of reset.

Configuration
REQ-017 Macro MC_ARB_STARVE_GUARD_EN defined: each port SHALL keep a saturating wait counter incremented per cycle with req=1, grant=0, cleared on grant.
REQ-018 With macro defined: a port whose counter reaches STARVE_LIMIT is urgent; lowest-index urgent port's requested outputs SHALL be withheld from other candidates until that port is granted.
REQ-019 Macro undefined: no counters, pure round-robin per REQ-006; no starvation bound guaranteed.

Structure
REQ-020 packet_pkg SHALL hold PORT_IDX_W (=$clog2(NUM_PORTS) for default), the port-index typedef, and the output state enum {FREE, BUSY}.
REQ-021 Per-output arbitration SHALL be a sub-module rr_pick (request vector, pointer in; one-hot winner out), instantiated NUM_PORTS times.

Verification
REQ-022 Reset: rst_n=0 mid-run -> grant=0, active=0, mux_sel=0 immediately; first grant after release follows pointer 0.
REQ-023 Multicast: p0 dst=0011, p1 dst=0010 same cycle, pointers 0 -> cycle+1 grant=0001, active=0011, mux_sel0=mux_sel1=0; p0 eop -> p1 granted two cycles after eop edge.
REQ-024 All-or-nothing: p2 dst=0110, p1 dst=0010 with ptr1=1 -> p1 granted, p2 not, ptr2 unchanged, output 2 stays FREE.
REQ-025 Round-robin: p0..p3 all dst=0001, one-flit packets (eop with grant) -> grant order p0,p1,p2,p3,p0.
REQ-026 Starvation (macro on, STARVE_LIMIT=4): p0 and p2 alternate one-flit packets to outputs 0 and 1, p1 dst=0011 -> p1 granted within 4 + 2 cycles of first request.
REQ-027 Ignore rules: eop on ungranted port and dst change during ownership -> no state change.
